// File: rtl/registers_param.sv
// Parametrised two-write-port register file with write-to-read bypass and a
// per-register busy scoreboard used by hazard logic.
module registers_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWr,
  input  logic [ADDR_W-1:0] Rw,
  input  logic [WIDTH-1:0]  busW,
  input  logic              RegWr2,
  input  logic [ADDR_W-1:0] Rw2,
  input  logic [WIDTH-1:0]  busW2,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  input  logic              SetBusy,
  input  logic [ADDR_W-1:0] Rbusy,
  output logic [WIDTH-1:0]  busA,
  output logic [WIDTH-1:0]  busB,
  output logic              busyA,
  output logic              busyB
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             we0, we1, set_en, byp_en;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Port 1 is checked first so forwarding agrees with the write that lands.
  function automatic logic [WIDTH-1:0] rd_data(input logic [ADDR_W-1:0] a);
    if (is_zero_reg(a))               return '0;
    else if (byp_en && we1 && Rw2 == a) return busW2;
    else if (byp_en && we0 && Rw == a)  return busW;
    else                              return mem_q[a];
  endfunction

  // A same-cycle write retires the producer unless a new one is issued to it.
  function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
    if (reset || is_zero_reg(a)) return 1'b0;
    else if (byp_en && ((we0 && Rw == a) || (we1 && Rw2 == a)) &&
             !(SetBusy && Rbusy == a))
      return 1'b0;
    else return busy_q[a];
  endfunction

  always_comb begin
    we0    = RegWr && !is_zero_reg(Rw);
    we1    = RegWr2 && !is_zero_reg(Rw2);
    set_en = SetBusy && !is_zero_reg(Rbusy);
    byp_en = (BYPASS != 0) && !reset;
  end

  always_comb begin
    busy_d = busy_q;
    if (we0)    busy_d[Rw]    = 1'b0;
    if (we1)    busy_d[Rw2]   = 1'b0;
    if (set_en) busy_d[Rbusy] = 1'b1;
  end

  always_comb begin
    busA  = rd_data(Ra);
    busB  = rd_data(Rb);
    busyA = rd_busy(Ra);
    busyB = rd_busy(Rb);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (we0) mem_q[Rw]  <= busW;
      if (we1) mem_q[Rw2] <= busW2;
      busy_q <= busy_d;
    end
  end

endmodule

// File: doc/registers_param.md
Name: registers_param

Overview:
- Parametrised successor to the 32x32 single-write register file.
- Adds two write ports with fixed priority and optional write-to-read bypass.
- Adds a per-register busy scoreboard for pending producers and a synchronous clear of the whole array.
- Sits in the CPU datapath between decode (Ra/Rb/Rw), writeback (busW ports) and hazard logic (busy outputs).

Parameters:
- WIDTH, 32, data width of every register and bus.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero: writes ignored, busy never set.
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports; 0 = reads return stored array only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- RegWr  in  1  write enable, port 0.
- Rw  in  ADDR_W  write address, port 0.
- busW  in  WIDTH  write data, port 0.
- RegWr2  in  1  write enable, port 1.
- Rw2  in  ADDR_W  write address, port 1.
- busW2  in  WIDTH  write data, port 1.
- Ra  in  ADDR_W  read address A.
- Rb  in  ADDR_W  read address B.
- SetBusy  in  1  mark register Rbusy as pending.
- Rbusy  in  ADDR_W  register to mark pending.
- busA  out  WIDTH  read data A (combinational).
- busB  out  WIDTH  read data B (combinational).
- busyA  out  1  register Ra has a pending producer.
- busyB  out  1  register Rb has a pending producer.

Behaviour:
- Storage: DEPTH x WIDTH array plus DEPTH busy bits.
- Reset: when reset=1 at a rising edge, all registers become 0 and all busy bits become 0. All writes and SetBusy in that cycle are ignored.
- While reset=1: bypass is suppressed, and busyA=busyB=0.
- Reset mid-operation discards all pending busy state.
- Writes: at the rising edge, each enabled port stores its bus into reg[Rw]. Write latency is 1 edge.
- Same-address write collision (RegWr && RegWr2 && Rw==Rw2): port 1 (busW2) wins.
- ZERO_REG=1: writes to address 0 are dropped, reads of address 0 return 0 (bypass included), and SetBusy with Rbusy=0 is ignored.
- Reads are asynchronous: busA = reg[Ra], busB = reg[Rb].
- BYPASS=1, reset=0: if RegWr2 && Rw2==Ra, busA = busW2; else if RegWr && Rw==Ra, busA = busW; else reg[Ra]. Same rule for B. Bypass priority matches write priority.
- Busy bits:
  - Any enabled write to address n clears busy[n] at the edge.
  - SetBusy sets busy[Rbusy] at the edge.
  - If SetBusy and a write target the same register in one cycle, set wins, because a new producer has been issued.
- busyA = busy[Ra], except when BYPASS=1 and a write to Ra occurs this cycle while Rbusy!=Ra or SetBusy=0; then busyA = 0. Same rule for busyB.
- busyA/busyB are always 0 for address 0 when ZERO_REG=1.
- Reads of an address with no write since reset return 0.
- Addresses are always in range (DEPTH = 2**ADDR_W); no wrap handling is needed.

Test Plan:
- Basic write/read: reset 1 cycle; RegWr=1, Rw=1, busW=32'hDEADBEEF; next cycle Ra=1, Rb=0 -> busA=32'hDEADBEEF, busB=0.
- Zero register: RegWr=1, Rw=0, busW=32'h12345678; then Ra=0 -> busA=0. Same write with ZERO_REG=0 -> busA=32'h12345678.
- Collision and bypass: RegWr=RegWr2=1, Rw=Rw2=3, busW=32'h1, busW2=32'h2, Ra=3 in the same cycle -> busA=32'h2 combinationally (BYPASS=1) and reg[3]=32'h2 after the edge. With BYPASS=0, busA shows the old value until the edge.
- Scoreboard: SetBusy=1, Rbusy=5 -> busyA=1 for Ra=5 from the next cycle. Then RegWr=1, Rw=5 -> busyA=0 in that same cycle (bypass) and busy[5] clear after the edge. SetBusy and write to 5 together -> busy stays 1.
- Reset mid-operation: write regs 1..4 with 32'hA..32'hD and set busy on 2; assert reset 1 cycle while RegWr=1, Rw=6, busW=32'hF -> all regs read 0 (including 6) and busyA=busyB=0.
- Parametrised build: WIDTH=16, ADDR_W=3; write 16'hFFFF to reg 7 -> read back 16'hFFFF. Then writing reg 7 on port 0 and reading Rb=7 with port 1 writing reg 6 -> busB=busW.
